// File: rtl/vga_pos_to_cell.sv
// Raster position -> game-matrix cell lookup. Computes cell/sub-cell indices,
// reads the map RAM, and returns an aligned per-pixel bundle 2 clk after input.
module vga_pos_to_cell #(
  parameter int H_VISIBLE_START = 336,
  parameter int H_VISIBLE_END   = 1615,
  parameter int V_VISIBLE_START = 27,
  parameter int V_VISIBLE_END   = 826,
  parameter int MAP_W           = 80,
  parameter int DATA_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic [11:0]       ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_data,
  output logic              out_valid,
  output logic              visible,
  output logic [6:0]        cell_x,
  output logic [5:0]        cell_y,
  output logic [3:0]        sub_x,
  output logic [3:0]        sub_y,
  output logic [DATA_W-1:0] cell_data,
  output logic              cell_enter,
  output logic              frame_start
);

  localparam int STAGES = 3;

  typedef struct packed {
    logic       vis;
    logic [6:0] cx;
    logic [5:0] cy;
    logic [3:0] sx;
    logic [3:0] sy;
    logic       frame;
  } meta_t;

  logic [STAGES:1] vld_pipe;
  meta_t           meta_in, meta_s1, meta_s2;
  logic            vis_in;
  logic [10:0]     x_off;
  logic [9:0]      y_off;
  logic [11:0]     row_base, addr_in;

  always_comb begin
    vis_in = (hcount >= 11'(H_VISIBLE_START)) && (hcount <= 11'(H_VISIBLE_END)) &&
             (vcount >= 10'(V_VISIBLE_START)) && (vcount <= 10'(V_VISIBLE_END));
    x_off  = hcount - 11'(H_VISIBLE_START);
    y_off  = vcount - 10'(V_VISIBLE_START);

    // Indices stay zero for bubbles and off-screen pixels so downstream sees clean zeros.
    meta_in       = '0;
    meta_in.frame = pix_en && (hcount == 11'd0) && (vcount == 10'd0);
    if (pix_en && vis_in) begin
      meta_in.vis = 1'b1;
      meta_in.cx  = x_off[10:4];
      meta_in.cy  = y_off[9:4];
      meta_in.sx  = x_off[3:0];
      meta_in.sy  = y_off[3:0];
    end

    // Constant multiply by MAP_W unrolled into shift-adds (80 -> <<6 + <<4).
    row_base = '0;
    for (int b = 0; b < 12; b++)
      if (MAP_W[b]) row_base = row_base + ({6'b0, meta_in.cy} << b);
    addr_in = row_base + {5'b0, meta_in.cx};
  end

  // Stage 1: RAM request plus metadata; stage 2: metadata waits for RAM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      meta_s1  <= '0;
      meta_s2  <= '0;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_en};
      meta_s1  <= meta_in;
      meta_s2  <= meta_s1;
      ram_rd   <= pix_en && vis_in;
      if (pix_en && vis_in) ram_addr <= addr_in;
    end
  end

  assign out_valid = vld_pipe[STAGES];

  // Stage 3: output bundle; RAM data masked off-screen since the read was skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      visible     <= 1'b0;
      cell_x      <= '0;
      cell_y      <= '0;
      sub_x       <= '0;
      sub_y       <= '0;
      cell_data   <= '0;
      cell_enter  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      visible     <= meta_s2.vis;
      cell_x      <= meta_s2.cx;
      cell_y      <= meta_s2.cy;
      sub_x       <= meta_s2.sx;
      sub_y       <= meta_s2.sy;
      cell_data   <= meta_s2.vis ? ram_data : '0;
      cell_enter  <= meta_s2.vis && (meta_s2.sx == 4'd0);
      frame_start <= meta_s2.frame;
    end
  end

endmodule

// File: tb/tb_vga_pos_to_cell.sv
// Scoreboard bench for vga_pos_to_cell: arithmetic reference model feeds a
// queue of expected bundles, a negedge monitor compares every cycle.
module tb_vga_pos_to_cell;

  logic        clk, rst, pix_en;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [11:0] ram_addr;
  logic        ram_rd;
  logic [3:0]  ram_data;
  logic        out_valid, visible, cell_enter, frame_start;
  logic [6:0]  cell_x;
  logic [5:0]  cell_y;
  logic [3:0]  sub_x, sub_y, cell_data;

  vga_pos_to_cell dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_data(ram_data),
    .out_valid(out_valid), .visible(visible), .cell_x(cell_x), .cell_y(cell_y),
    .sub_x(sub_x), .sub_y(sub_y), .cell_data(cell_data),
    .cell_enter(cell_enter), .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous map RAM
  logic [3:0] mem [0:4095];
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  typedef struct {
    int         due;
    logic [28:0] bundle;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_tests = 0, n_fail = 0;
  int         ce_cnt = 0, fs_cnt = 0;
  logic       exp_rd = 1'b0;
  logic [11:0] exp_addr = '0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  // Reference model: visibility window, divide/modulo by 16, row*80+col.
  always @(posedge clk) begin
    int h, v, cx, cy, sx, sy;
    logic vis, ce, fs;
    logic [3:0] d;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      exp_rd   = 1'b0;
      exp_addr = '0;
    end else begin
      h   = int'(hcount);
      v   = int'(vcount);
      vis = (h >= 336) && (h <= 1615) && (v >= 27) && (v <= 826);
      cx = 0; cy = 0; sx = 0; sy = 0; d = 4'd0;
      if (vis) begin
        cx = (h - 336) / 16;  sx = (h - 336) % 16;
        cy = (v - 27) / 16;   sy = (v - 27) % 16;
        d  = mem[cy * 80 + cx];
      end
      exp_rd = pix_en && vis;
      if (exp_rd) exp_addr = 12'(cy * 80 + cx);
      if (pix_en) begin
        ce = vis && (sx == 0);
        fs = (h == 0) && (v == 0);
        e.due    = cyc + 2;
        e.bundle = {vis, 7'(cx), 6'(cy), 4'(sx), 4'(sy), d, ce, fs};
        q.push_back(e);
      end
    end
  end

  // Monitor: every cycle either the queue head is due or the output is idle/zero.
  always @(negedge clk) begin
    logic        ev;
    logic [28:0] want;
    if (cyc >= 1) begin
      ev = 1'b0;
      want = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev   = 1'b1;
        want = q[0].bundle;
        void'(q.pop_front());
      end
      check("out_valid", 64'(out_valid), 64'(ev));
      check("bundle{vis,cx,cy,sx,sy,data,enter,frame}",
            64'({visible, cell_x, cell_y, sub_x, sub_y, cell_data, cell_enter, frame_start}),
            64'(want));
      check("ram{rd,addr}", 64'({ram_rd, ram_addr}), 64'({exp_rd, exp_addr}));
      if (out_valid && cell_enter) ce_cnt++;
      if (out_valid && frame_start) fs_cnt++;
    end
  end

  task automatic drive(input logic pe, input int h, input int v, input logic r);
    @(negedge clk);
    pix_en = pe;
    hcount = 11'(h);
    vcount = 10'(v);
    rst    = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic sweep_line(input int v, input int ce_want, input int fs_want);
    idle(4);
    ce_cnt = 0;
    fs_cnt = 0;
    for (int h = 0; h < 2048; h++) drive(1'b1, h, v, 1'b0);
    idle(4);
    check($sformatf("cell_enter_count_v%0d", v), 64'(ce_cnt), 64'(ce_want));
    check($sformatf("frame_start_count_v%0d", v), 64'(fs_cnt), 64'(fs_want));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 4'($urandom);
    rst = 1'b1; pix_en = 1'b1; hcount = 11'd400; vcount = 10'd100;
    drive(1'b1, 400, 100, 1'b1);
    drive(1'b1, 400, 100, 1'b1);

    // Directed: origin, cell centre, far corner, just past corners
    drive(1'b1, 336, 27, 1'b0);
    drive(1'b1, 423, 82, 1'b0);
    drive(1'b1, 1615, 826, 1'b0);
    drive(1'b1, 1616, 826, 1'b0);
    drive(1'b1, 335, 27, 1'b0);
    drive(1'b1, 336, 26, 1'b0);
    drive(1'b1, 336, 827, 1'b0);
    drive(1'b1, 2047, 1023, 1'b0);
    drive(1'b1, 0, 0, 1'b0);
    idle(3);

    // Random mix with bubbles and occasional reset
    for (int i = 0; i < 3000; i++) begin
      int h, v;
      h = ($urandom_range(1) != 0) ? int'($urandom_range(2047)) : int'($urandom_range(1700, 300));
      v = ($urandom_range(1) != 0) ? int'($urandom_range(1023)) : int'($urandom_range(860, 0));
      drive(1'($urandom_range(3) != 0), h, v, 1'($urandom_range(99) == 0));
    end
    idle(3);

    // Gapped pix_en with a reset pulse mid-line
    for (int h = 336; h < 536; h++)
      drive(1'(h[0] == 1'b0), h, 300, 1'(h == 437));
    idle(3);

    sweep_line(0, 0, 1);
    sweep_line(26, 0, 0);
    sweep_line(27, 80, 0);
    sweep_line(400, 80, 0);
    sweep_line(826, 80, 0);
    sweep_line(827, 0, 0);

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
